// File: rtl/ows_slave_rx.sv
`default_nettype none
// ============================================================================
// Module      : ows_slave_rx
// Description : 1-Wire slave receiver front-end. Synchronises DQ, measures
//               low pulses, recognises bus resets and answers them with a
//               timed presence pulse, decodes LSB-first write slots into
//               DATA_WIDTH-bit words and offers them on a one-entry
//               valid/ready output with overrun/abort error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module ows_slave_rx #(
   parameter int DATA_WIDTH    = 8,
   parameter int CNT_W         = 16,
   parameter int GLITCH_CYC    = 50,
   parameter int SAMPLE_CYC    = 750,
   parameter int RESET_CYC     = 24000,
   parameter int PRES_WAIT_CYC = 1500,
   parameter int PRES_LEN_CYC  = 6000,
   parameter int PRESENCE_EN   = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  dq_in,
   output logic                  dq_drive_low,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   output logic                  bus_reset,
   output logic                  err_abort,
   output logic                  err_overrun,
   output logic [7:0]            word_cnt
);

   localparam int BC_W = $clog2(DATA_WIDTH + 1);

   localparam logic [CNT_W-1:0] c_glitch   = CNT_W'(GLITCH_CYC);
   localparam logic [CNT_W-1:0] c_sample   = CNT_W'(SAMPLE_CYC);
   localparam logic [CNT_W-1:0] c_reset    = CNT_W'(RESET_CYC);
   localparam logic [CNT_W-1:0] c_pw_last  = CNT_W'(PRES_WAIT_CYC - 1);
   localparam logic [CNT_W-1:0] c_pl_last  = CNT_W'(PRES_LEN_CYC - 1);
   localparam logic [BC_W-1:0]  c_last_bit = BC_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_SLOT       = 3'd1,
      ST_RST_HOLD   = 3'd2,
      ST_PRES_WAIT  = 3'd3,
      ST_PRES_DRIVE = 3'd4,
      ST_PRES_REL   = 3'd5
   } state_t;

   state_t                state_q,     state_d;
   logic [1:0]            sync_q,      sync_d;
   logic [CNT_W-1:0]      low_cnt_q,   low_cnt_d;
   logic [CNT_W-1:0]      tmr_q,       tmr_d;
   logic [BC_W-1:0]       bit_cnt_q,   bit_cnt_d;
   logic [DATA_WIDTH-1:0] shift_q,     shift_d;
   logic [DATA_WIDTH-1:0] rx_data_q,   rx_data_d;
   logic                  rx_valid_q,  rx_valid_d;
   logic                  drive_q,     drive_d;
   logic                  bus_reset_q, bus_reset_d;
   logic                  abort_q,     abort_d;
   logic                  overrun_q,   overrun_d;
   logic [7:0]            word_cnt_q,  word_cnt_d;
   logic                  s;
   logic                  bit_val;

   // Synchronised line level: every decision below is taken on this only.
   assign s = sync_q[1];

   // Next-state computation for the slot decoder, presence sequencer and output word register.
   always_comb begin
      state_d     = state_q;
      sync_d      = {sync_q[0], dq_in};
      low_cnt_d   = low_cnt_q;
      tmr_d       = tmr_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      drive_d     = 1'b0;
      bus_reset_d = 1'b0;
      abort_d     = 1'b0;
      overrun_d   = 1'b0;
      word_cnt_d  = word_cnt_q;
      bit_val     = 1'b0;

      // Consumer handshake; a word completing in this cycle overrides it below.
      if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (!s) begin
               state_d   = ST_SLOT;
               low_cnt_d = CNT_W'(1);
            end
         end

         ST_SLOT: begin
            if (!s) begin
               if (low_cnt_q != c_reset) begin
                  low_cnt_d = low_cnt_q + CNT_W'(1);
               end
               if (low_cnt_d == c_reset) begin
                  state_d     = ST_RST_HOLD;
                  bus_reset_d = 1'b1;
                  abort_d     = (bit_cnt_q != '0);
                  bit_cnt_d   = '0;
                  word_cnt_d  = '0;
               end
            end else begin
               state_d = ST_IDLE;
               // Pulses shorter than the glitch threshold leave the decoder untouched.
               if (low_cnt_q >= c_glitch) begin
                  bit_val = (low_cnt_q < c_sample);
                  shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
                  if (bit_cnt_q == c_last_bit) begin
                     bit_cnt_d = '0;
                     if (!rx_valid_q || rx_ready) begin
                        rx_data_d  = shift_d;
                        rx_valid_d = 1'b1;
                        if (word_cnt_q != 8'hFF) begin
                           word_cnt_d = word_cnt_q + 8'd1;
                        end
                     end else begin
                        overrun_d = 1'b1;
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q + BC_W'(1);
                  end
               end
            end
         end

         ST_RST_HOLD: begin
            if (s) begin
               tmr_d   = '0;
               state_d = (PRESENCE_EN != 0) ? ST_PRES_WAIT : ST_IDLE;
            end
         end

         ST_PRES_WAIT: begin
            if (tmr_q == c_pw_last) begin
               tmr_d   = '0;
               drive_d = 1'b1;
               state_d = ST_PRES_DRIVE;
            end else begin
               tmr_d = tmr_q + CNT_W'(1);
            end
         end

         ST_PRES_DRIVE: begin
            if (tmr_q == c_pl_last) begin
               tmr_d   = '0;
               state_d = ST_PRES_REL;
            end else begin
               tmr_d   = tmr_q + CNT_W'(1);
               drive_d = 1'b1;
            end
         end

         ST_PRES_REL: begin
            // Our own pulse (or another device's) keeps the line low here; only leave once it is high.
            if (s) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         sync_q      <= 2'b11;
         low_cnt_q   <= '0;
         tmr_q       <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         drive_q     <= 1'b0;
         bus_reset_q <= 1'b0;
         abort_q     <= 1'b0;
         overrun_q   <= 1'b0;
         word_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         sync_q      <= sync_d;
         low_cnt_q   <= low_cnt_d;
         tmr_q       <= tmr_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         drive_q     <= drive_d;
         bus_reset_q <= bus_reset_d;
         abort_q     <= abort_d;
         overrun_q   <= overrun_d;
         word_cnt_q  <= word_cnt_d;
      end
   end

   assign dq_drive_low = drive_q;
   assign rx_data      = rx_data_q;
   assign rx_valid     = rx_valid_q;
   assign bus_reset    = bus_reset_q;
   assign err_abort    = abort_q;
   assign err_overrun  = overrun_q;
   assign word_cnt     = word_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ows_slave_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ows_slave_rx
// Description : Directed/randomised bench for ows_slave_rx. A bus master
//               model drives write slots and reset pulses on a wired-AND DQ
//               line; a word-level reference model predicts the receiver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ows_slave_rx;

   localparam int DW = 8;
   localparam int GL = 6;
   localparam int SA = 30;
   localparam int RS = 300;
   localparam int PW = 25;
   localparam int PL = 60;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          dq_m0 = 1'b1;
   logic          dq_m1 = 1'b1;
   logic          ready0 = 1'b0;
   logic          ready1 = 1'b0;
   logic          line0, line1;
   logic          drive0, drive1;
   logic [DW-1:0] data0, data1;
   logic          valid0, valid1;
   logic          br0, br1, ab0, ab1, ov0, ov1;
   logic [7:0]    wc0, wc1;

   int checks = 0;
   int errors = 0;

   // reference model state
   bit            exp_valid = 1'b0;
   logic [DW-1:0] exp_data  = '0;
   int            exp_wcnt  = 0;

   always #5 clk = ~clk;

   // open-drain bus: master and slave both pull low
   assign line0 = dq_m0 & ~drive0;
   assign line1 = dq_m1 & ~drive1;

   ows_slave_rx #(
      .DATA_WIDTH(DW), .CNT_W(16), .GLITCH_CYC(GL), .SAMPLE_CYC(SA),
      .RESET_CYC(RS), .PRES_WAIT_CYC(PW), .PRES_LEN_CYC(PL), .PRESENCE_EN(1)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .dq_in(line0), .dq_drive_low(drive0),
      .rx_data(data0), .rx_valid(valid0), .rx_ready(ready0),
      .bus_reset(br0), .err_abort(ab0), .err_overrun(ov0), .word_cnt(wc0)
   );

   ows_slave_rx #(
      .DATA_WIDTH(DW), .CNT_W(16), .GLITCH_CYC(GL), .SAMPLE_CYC(SA),
      .RESET_CYC(RS), .PRES_WAIT_CYC(PW), .PRES_LEN_CYC(PL), .PRESENCE_EN(0)
   ) u_dut_np (
      .clk(clk), .rst_n(rst_n), .dq_in(line1), .dq_drive_low(drive1),
      .rx_data(data1), .rx_valid(valid1), .rx_ready(ready1),
      .bus_reset(br1), .err_abort(ab1), .err_overrun(ov1), .word_cnt(wc1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic glitch_opt(input bit en);
      if (en && $urandom_range(0, 2) == 0) begin
         dq_m0 = 1'b0;
         tick(int'($urandom_range(1, GL - 2)));
         dq_m0 = 1'b1;
         tick(10);
      end
   endtask

   // low phase of one write slot; bit 1 is a short low, bit 0 a long low
   task automatic bit_low(input bit b);
      int lo;
      lo = b ? int'($urandom_range(GL + 2, SA - 2)) : int'($urandom_range(SA + 2, SA + 60));
      dq_m0 = 1'b0;
      tick(lo);
      dq_m0 = 1'b1;
   endtask

   // mode 0: rx_ready low; 1: rx_ready high throughout; 2: rx_ready rises on the completing cycle
   task automatic send_word(input logic [DW-1:0] data, input int mode, input bit gl);
      ready0 = (mode == 1);
      if (mode == 1) exp_valid = 1'b0;
      for (int i = 0; i < DW; i++) begin
         glitch_opt(gl);
         bit_low(data[i]);
         if (i != DW - 1) tick(int'($urandom_range(10, 30)));
      end
      if (mode == 2) begin
         tick(2);
         ready0 = 1'b1;
         tick(1);
      end else begin
         tick(3);
      end
      if (!exp_valid || mode != 0) begin
         exp_valid = 1'b1;
         exp_data  = data;
         if (exp_wcnt < 255) exp_wcnt++;
         check("overrun_quiet", 32'(ov0), 32'd0);
      end else begin
         check("overrun_pulse", 32'(ov0), 32'd1);
      end
      check("rx_valid", 32'(valid0), 32'(exp_valid));
      check("rx_data", 32'(data0), 32'(exp_data));
      check("word_cnt", 32'(wc0), 32'(exp_wcnt));
      if (mode != 0) begin
         tick(1);
         check("rx_valid_clear", 32'(valid0), 32'd0);
         exp_valid = 1'b0;
      end
      tick(12);
   endtask

   // bus reset pulse from the master with presence pulse measurement
   task automatic do_reset(input bit exp_abort);
      int n_br, n_ab, n_both, n;
      n_br = 0; n_ab = 0; n_both = 0;
      dq_m0 = 1'b0;
      repeat (RS + 20) begin
         tick(1);
         n_br   += int'(br0);
         n_ab   += int'(ab0);
         n_both += int'(br0 & ab0);
      end
      check("bus_reset_count", 32'(n_br), 32'd1);
      check("abort_count", 32'(n_ab), 32'(exp_abort));
      check("abort_with_reset", 32'(n_both), 32'(exp_abort));
      dq_m0 = 1'b1;
      n = 0;
      while (!drive0 && n < PW + 50) begin
         tick(1);
         n++;
      end
      check("presence_delay", 32'(n), 32'(PW + 3));
      n = 0;
      while (drive0 && n < PL + 50) begin
         tick(1);
         n++;
      end
      check("presence_len", 32'(n), 32'(PL));
      tick(10);
      exp_wcnt = 0;
      check("word_cnt_after_reset", 32'(wc0), 32'd0);
      check("rx_valid_kept", 32'(valid0), 32'(exp_valid));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int n, n_br, n_drv;
      logic [DW-1:0] d;

      // power-on reset
      tick(3);
      check("rst_drive", 32'(drive0), 32'd0);
      check("rst_valid", 32'(valid0), 32'd0);
      check("rst_data", 32'(data0), 32'd0);
      check("rst_pulses", {29'd0, br0, ab0, ov0}, 32'd0);
      check("rst_word_cnt", 32'(wc0), 32'd0);
      rst_n = 1'b1;
      tick(5);

      // reset pulse with presence answer
      do_reset(1'b0);

      // single word, consumer ready
      send_word(8'hA5, 1, 1'b0);

      // held word then overrun, consumer stalled
      send_word(8'h3C, 0, 1'b0);
      send_word(8'hFF, 0, 1'b0);
      ready0 = 1'b1;
      tick(1);
      check("stall_release", 32'(valid0), 32'd0);
      exp_valid = 1'b0;
      ready0 = 1'b0;
      tick(5);

      // randomised words with glitches and mixed handshake timing
      for (int k = 0; k < 6; k++) begin
         d = DW'($urandom);
         send_word(d, int'($urandom_range(0, 2)), 1'b1);
      end
      ready0 = 1'b1;
      tick(2);
      exp_valid = 1'b0;

      // glitches plus partial word, then reset aborts it
      for (int i = 0; i < 3; i++) begin
         glitch_opt(1'b1);
         bit_low(1'($urandom));
         tick(15);
      end
      do_reset(1'b1);
      d = DW'($urandom);
      send_word(d, 1, 1'b1);

      // pending word survives a bus reset
      send_word(8'h5A, 0, 1'b0);
      do_reset(1'b0);
      check("pending_data_kept", 32'(data0), 32'h5A);

      // presence disabled: reset recognised, line never driven
      n_br = 0; n_drv = 0;
      dq_m1 = 1'b0;
      repeat (RS + 20) begin
         tick(1);
         n_br  += int'(br1);
         n_drv += int'(drive1);
      end
      dq_m1 = 1'b1;
      repeat (2 * (PW + PL)) begin
         tick(1);
         n_drv += int'(drive1);
      end
      check("np_bus_reset", 32'(n_br), 32'd1);
      check("np_no_presence", 32'(n_drv), 32'd0);

      // rst_n while presence is being driven
      dq_m0 = 1'b0;
      tick(RS + 20);
      dq_m0 = 1'b1;
      n = 0;
      while (!drive0 && n < PW + 50) begin
         tick(1);
         n++;
      end
      check("pre_reset_drive", 32'(drive0), 32'd1);
      tick(5);
      rst_n = 1'b0;
      tick(1);
      check("mid_rst_drive", 32'(drive0), 32'd0);
      check("mid_rst_valid", 32'(valid0), 32'd0);
      check("mid_rst_data", 32'(data0), 32'd0);
      check("mid_rst_word_cnt", 32'(wc0), 32'd0);
      check("mid_rst_pulses", {29'd0, br0, ab0, ov0}, 32'd0);
      rst_n = 1'b1;
      exp_valid = 1'b0;
      exp_wcnt = 0;
      tick(10);
      check("post_rst_idle_drive", 32'(drive0), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ows_slave_rx.md
# ows_slave_rx

Parametrised 1-Wire slave receiver front-end. It samples the open-drain DQ line, detects bus reset pulses, and answers them with a timed presence pulse. It decodes LSB-first write slots into DATA_WIDTH-bit words and hands each word to the slave's command layer over a single-entry valid/ready interface, flagging overrun and aborted-word errors. All timing is in clk cycles; the defaults correspond to a 50 MHz clk and standard-speed 1-Wire.

## Interface
- DATA_WIDTH, 8: bits per received word, 2..32.
- CNT_W, 16: width of the slot/timer counter; every timing parameter must be < 2^CNT_W.
- GLITCH_CYC, 50: low pulses shorter than this are ignored (1 µs).
- SAMPLE_CYC, 750: low duration threshold; a slot shorter than this decodes as 1, otherwise 0 (15 µs).
- RESET_CYC, 24000: low duration at or above this is a bus reset (480 µs).
- PRES_WAIT_CYC, 1500: delay from reset release to presence drive (30 µs).
- PRES_LEN_CYC, 6000: presence pulse length (120 µs).
- PRESENCE_EN, 1: 0 suppresses the presence pulse; the reset is still detected.
- clk, in, 1: single clock.
- rst_n, in, 1: synchronous, active-low reset.
- dq_in, in, 1: raw DQ line level (asynchronous).
- dq_drive_low, out, 1: 1 = pull DQ low (presence pulse).
- rx_data, out, DATA_WIDTH: received word, valid while rx_valid = 1.
- rx_valid, out, 1: word available.
- rx_ready, in, 1: consumer accepts the word when rx_valid && rx_ready.
- bus_reset, out, 1: one-cycle pulse when a reset pulse is recognised.
- err_abort, out, 1: one-cycle pulse when a reset arrives with 1..DATA_WIDTH-1 bits collected.
- err_overrun, out, 1: one-cycle pulse when a completed word is dropped.
- word_cnt, out, 8: words delivered since the last bus reset; saturates at 255.

## Operation
- dq_in passes through a 2-flop synchroniser. The synchronised level is s. All decisions use s only.
- State IDLE:
  - s = 0 → SLOT with low_cnt = 1.
- State SLOT, each cycle with s = 0:
  - low_cnt increments, saturating at RESET_CYC.
  - When low_cnt reaches RESET_CYC → RST_HOLD. Pulse bus_reset. Pulse err_abort if bit_cnt ≠ 0. Clear bit_cnt and word_cnt.
- State SLOT, first cycle with s = 1, classify by low_cnt:
  - low_cnt < GLITCH_CYC: ignore.
  - low_cnt < SAMPLE_CYC: bit = 1.
  - Otherwise: bit = 0.
  - Return to IDLE in all cases.
- Bit shift: the bit is shifted in LSB-first, so the first bit received lands in rx_data[0].
- Word completion: when bit_cnt reaches DATA_WIDTH, the word completes and bit_cnt returns to 0.
  - Output register empty, or rx_valid && rx_ready in the same cycle: load rx_data, set rx_valid, increment word_cnt.
  - Otherwise: drop the word, pulse err_overrun, leave rx_data/rx_valid unchanged.
- Handshake: rx_valid && rx_ready with no completing word → rx_valid clears next edge.
- State RST_HOLD: wait for s = 1.
  - PRESENCE_EN = 1 → PRES_WAIT.
  - PRESENCE_EN = 0 → IDLE.
- State PRES_WAIT: count PRES_WAIT_CYC cycles → PRES_DRIVE.
- State PRES_DRIVE: dq_drive_low = 1 for exactly PRES_LEN_CYC cycles → PRES_REL.
- State PRES_REL: dq_drive_low = 0; wait for s = 1 → IDLE.
  - A line held low by another device must not be decoded as a slot.
- Line activity during PRES_WAIT/PRES_DRIVE is ignored.
- A bus reset does not clear a pending rx_valid word.

## Timing
- Reset values, synchronous on rst_n = 0:
  - state IDLE; dq_drive_low = 0; rx_valid = 0; rx_data = 0.
  - bus_reset = err_abort = err_overrun = 0; word_cnt = 0; bit_cnt = 0; synchroniser = 1.
- Reset mid-operation (including PRES_DRIVE) releases dq_drive_low on that edge.
- Input latency: a dq_in edge is visible on s 2 cycles later.
- Measured low time equals the true low time ± 1 cycle.
- rx_valid rises 1 cycle after the s rising edge of the last bit, i.e. 3 cycles after the dq_in rising edge.
- bus_reset pulses on the cycle low_cnt hits RESET_CYC, i.e. while DQ is still low.
- dq_drive_low rises PRES_WAIT_CYC + 1 cycles after s goes high in RST_HOLD, and stays high for exactly PRES_LEN_CYC cycles.
- bus_reset, err_abort and err_overrun are single-cycle, registered pulses.
- err_abort and bus_reset may pulse in the same cycle.
- word_cnt updates in the same edge that sets rx_valid.

## Test plan
- Reset sequence: rst_n low 3 cycles, then dq low 24100 cycles → bus_reset pulses once. Release dq → dq_drive_low high for 6000 cycles after a 1501-cycle delay. word_cnt = 0.
- Write 0xA5 LSB-first (bit 1 = 300-cycle low, bit 0 = 3000-cycle low, 3500-cycle recovery) with rx_ready = 1 → rx_data = 0xA5, rx_valid for 1 cycle, word_cnt = 1.
- Two words 0x3C, 0xFF with rx_ready = 0 → first word is held, err_overrun pulses at the second word, rx_data stays 0x3C. Raise rx_ready → rx_valid clears.
- Glitch and abort: 20-cycle low pulses are ignored (bit_cnt unchanged). Send 3 bits, then a reset → err_abort and bus_reset pulse together, and the next word decodes cleanly.
- PRESENCE_EN = 0 → a reset pulse gives bus_reset but dq_drive_low never asserts.
- rst_n asserted mid-PRES_DRIVE → dq_drive_low = 0 on that edge and all outputs return to their reset values.
